// File: rtl/jtag_pkg.sv
// Shared types, TAP walk lengths and width helpers for the JTAG TAP master.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR_INIT,
    IDLE,
    IR_SEL,
    IR_SHIFT,
    IR_UPD,
    DR_SEL,
    DR_SHIFT,
    DR_UPD,
    RESP
  } tap_state_e;

  // Fixed TMS walks, expressed as (steps, leading ones):
  //   TLR_INIT 1,1,1,1,1,0   IR_SEL 1,1,0,0   IR/DR_UPD 1,0   DR_SEL 1,0,0
  localparam int unsigned TLR_STEPS       = 6;
  localparam int unsigned TLR_TMS_ONES    = 5;
  localparam int unsigned IR_SEL_STEPS    = 4;
  localparam int unsigned IR_SEL_TMS_ONES = 2;
  localparam int unsigned UPD_STEPS       = 2;
  localparam int unsigned DR_SEL_STEPS    = 3;

  function automatic int unsigned address_width(input int unsigned n_regs);
    return $clog2(n_regs + 1);
  endfunction

  function automatic int unsigned ir_width(input int unsigned n_regs);
    return address_width(n_regs) + 1;
  endfunction

endpackage

// File: rtl/jtag_tap_master_if.sv
// Command/response handshake between a host and the JTAG TAP master.
interface jtag_tap_master_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned REGISTER_SIZE = 32
);
  logic                     iCMD_VALID;
  logic                     oCMD_READY;
  logic                     iCMD_WRITE;
  logic [ADDRESS_WIDTH-1:0] iCMD_ADDRESS;
  logic [REGISTER_SIZE-1:0] iCMD_DATA;
  logic                     oRSP_VALID;
  logic [REGISTER_SIZE-1:0] oRSP_DATA;

  modport master (
    output iCMD_VALID, iCMD_WRITE, iCMD_ADDRESS, iCMD_DATA,
    input  oCMD_READY, oRSP_VALID, oRSP_DATA
  );

  modport slave (
    input  iCMD_VALID, iCMD_WRITE, iCMD_ADDRESS, iCMD_DATA,
    output oCMD_READY, oRSP_VALID, oRSP_DATA
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: divides the system clock, emits one-cycle strobes in the
// cycle before TCK rises or falls. Disabled means TCK parked low, counter cleared.
module jtag_tck_gen #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tck_q;
  logic             tick;

  assign tick   = en_i && (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign rise_o = tick && !tck_q;
  assign fall_o = tick && tck_q;
  assign tck_o  = tck_q;

  // Half-period counter and TCK toggle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/jtag_tap_master.sv
// JTAG initiator: turns register read/write commands into an IR scan of
// {WRITE,ADDRESS} followed by a REGISTER_SIZE-bit DR scan, returning TDO bits.
module jtag_tap_master
  import jtag_pkg::*;
#(
  parameter int unsigned NUMBER_OF_REGISTERS = 16,
  parameter int unsigned REGISTER_SIZE       = 32,
  parameter int unsigned TCK_HALF_PERIOD     = 4
) (
  input  logic              iMAIN_CLK,
  input  logic              iRESET,
  jtag_tap_master_if.slave  bus,
  output logic              oTCK,
  output logic              oTMS,
  output logic              oTDI,
  input  logic              iTDO
);
  localparam int unsigned AW       = address_width(NUMBER_OF_REGISTERS);
  localparam int unsigned IRW      = ir_width(NUMBER_OF_REGISTERS);
  localparam int unsigned SCAN_MAX = (IRW > REGISTER_SIZE) ? IRW : REGISTER_SIZE;
  localparam int unsigned CNT_MAX  = (SCAN_MAX > TLR_STEPS) ? SCAN_MAX : TLR_STEPS;
  localparam int unsigned CW       = $clog2(CNT_MAX);

  tap_state_e               state_q, state_d, next_phase;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IRW-1:0]           ir_q, ir_d;
  logic [REGISTER_SIZE-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [REGISTER_SIZE-1:0] rsp_data_q;
  logic                     rsp_valid_q;
  logic                     tms_q, tms_d, tdi_q, tdi_d;
  logic                     accept, tck_en, tck_rise, tck_fall;
  int unsigned              step_len;

  assign accept = (state_q == IDLE) && bus.iCMD_VALID;
  assign tck_en = (state_q != IDLE) && (state_q != RESP);

  jtag_tck_gen #(.HALF_PERIOD(TCK_HALF_PERIOD)) u_tck_gen (
    .clk_i  (iMAIN_CLK),
    .rst_i  (iRESET),
    .en_i   (tck_en),
    .tck_o  (oTCK),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  // Step sequencing: a TAP step ends on the TCK falling edge, where the
  // TMS/TDI of the following step are launched from the next-state values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    tms_d      = 1'b0;
    tdi_d      = 1'b0;
    step_len   = 1;
    next_phase = IDLE;

    case (state_q)
      TLR_INIT: begin step_len = TLR_STEPS;     next_phase = IDLE;     end
      IR_SEL:   begin step_len = IR_SEL_STEPS;  next_phase = IR_SHIFT; end
      IR_SHIFT: begin step_len = IRW;           next_phase = IR_UPD;   end
      IR_UPD:   begin step_len = UPD_STEPS;     next_phase = DR_SEL;   end
      DR_SEL:   begin step_len = DR_SEL_STEPS;  next_phase = DR_SHIFT; end
      DR_SHIFT: begin step_len = REGISTER_SIZE; next_phase = DR_UPD;   end
      DR_UPD:   begin step_len = UPD_STEPS;     next_phase = RESP;     end
      default:  begin step_len = 1;             next_phase = IDLE;     end
    endcase

    if (state_q == IDLE) begin
      if (accept) begin
        state_d = IR_SEL;
        cnt_d   = '0;
        ir_d    = {bus.iCMD_WRITE, bus.iCMD_ADDRESS};
        tx_d    = bus.iCMD_WRITE ? bus.iCMD_DATA : '0;
        rx_d    = '0;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (tck_fall) begin
      if (state_q == IR_SHIFT) ir_d = ir_q >> 1;
      if (state_q == DR_SHIFT) tx_d = tx_q >> 1;
      if (cnt_q == CW'(step_len - 1)) begin
        state_d = next_phase;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (tck_rise && state_q == DR_SHIFT) rx_d = {iTDO, rx_q[REGISTER_SIZE-1:1]};

    case (state_d)
      TLR_INIT: tms_d = (cnt_d < CW'(TLR_TMS_ONES));
      IR_SEL:   tms_d = (cnt_d < CW'(IR_SEL_TMS_ONES));
      IR_SHIFT: begin
        tms_d = (cnt_d == CW'(IRW - 1));
        tdi_d = ir_d[0];
      end
      IR_UPD:   tms_d = (cnt_d == '0);
      DR_SEL:   tms_d = (cnt_d == '0);
      DR_SHIFT: begin
        tms_d = (cnt_d == CW'(REGISTER_SIZE - 1));
        tdi_d = tx_d[0];
      end
      DR_UPD:   tms_d = (cnt_d == '0);
      default:  tms_d = 1'b0;
    endcase
  end

  // State, shift registers, JTAG pins and response registers.
  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      state_q     <= TLR_INIT;
      cnt_q       <= '0;
      ir_q        <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ir_q        <= ir_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= (state_d == RESP);
      if (state_d == RESP && state_q != RESP) rsp_data_q <= rx_q;
    end
  end

  assign oTMS           = tms_q;
  assign oTDI           = tdi_q;
  assign bus.oCMD_READY = (state_q == IDLE);
  assign bus.oRSP_VALID = rsp_valid_q;
  assign bus.oRSP_DATA  = rsp_data_q;
endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: IEEE 1149.1 TAP model with a 16x32 register file
// on the JTAG pins, plus an expected register image updated per command.
module tb_jtag_tap_master;
  localparam int unsigned NREG = 16;
  localparam int unsigned RSZ  = 32;
  localparam int unsigned AW   = $clog2(NREG + 1);
  localparam int unsigned IRW  = AW + 1;

  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;

  logic clk = 1'b0;
  logic rst;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_tap_master_if #(.ADDRESS_WIDTH(AW), .REGISTER_SIZE(RSZ)) bus ();

  jtag_tap_master #(
    .NUMBER_OF_REGISTERS (NREG),
    .REGISTER_SIZE       (RSZ),
    .TCK_HALF_PERIOD     (2)
  ) dut (
    .iMAIN_CLK (clk),
    .iRESET    (rst),
    .bus       (bus.slave),
    .oTCK      (tck),
    .oTMS      (tms),
    .oTDI      (tdi),
    .iTDO      (tdo)
  );

  function automatic logic [31:0] preload(input int unsigned i);
    return (i == 0) ? 32'hA5A5A5A5 : 32'h1000_0000 + i * 32'h0111_0111;
  endfunction

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // Target-side TAP model; starts in Shift-DR so recovery must come from TMS.
  tap_e            tap = SHDR;
  logic [31:0]     tgt_reg [NREG];
  logic [IRW-1:0]  ir_sr, ir_reg = '0;
  logic [31:0]     dr_sr = '0;
  logic [63:0]     tms_hist = '0;
  int unsigned     shift_cnt = 0, rise_n = 0;
  logic            tdi_or = 1'b0;

  initial begin
    for (int unsigned i = 0; i < NREG; i++) tgt_reg[i] = preload(i);
    forever begin
      @(posedge tck);
      rise_n++;
      tms_hist = {tms_hist[62:0], tms};
      case (tap)
        CAPDR: begin
          dr_sr = ir_reg[IRW-2] ? 32'h0 : tgt_reg[ir_reg[3:0]];
          shift_cnt = 0;
          tdi_or = 1'b0;
        end
        SHDR: begin
          dr_sr = {tdi, dr_sr[31:1]};
          shift_cnt++;
          tdi_or = tdi_or | tdi;
        end
        CAPIR: ir_sr = IRW'(1);
        SHIR:  ir_sr = {tdi, ir_sr[IRW-1:1]};
        UPIR:  ir_reg = ir_sr;
        UPDR:  if (ir_reg[IRW-1] && !ir_reg[IRW-2]) tgt_reg[ir_reg[3:0]] = dr_sr;
        default: ;
      endcase
      tap = tap_next(tap, tms);
    end
  end

  always @(negedge tck) tdo = (tap == SHDR) ? dr_sr[0] : 1'b0;

  int unsigned rsp_n = 0;
  always @(negedge clk) if (bus.oRSP_VALID) rsp_n++;

  logic [31:0] exp_reg [NREG];
  int unsigned n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      if (bus.oCMD_READY) ok = 1;
      else @(negedge clk);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic cmd_start(input logic w, input logic [3:0] a, input logic [31:0] d);
    wait_ready("ready_timeout");
    bus.iCMD_VALID   = 1'b1;
    bus.iCMD_WRITE   = w;
    bus.iCMD_ADDRESS = {1'b0, a};
    bus.iCMD_DATA    = d;
    @(negedge clk);
    bus.iCMD_VALID   = 1'b0;
    bus.iCMD_WRITE   = 1'($urandom);
    bus.iCMD_ADDRESS = 5'($urandom);
    bus.iCMD_DATA    = $urandom;
  endtask

  task automatic cmd_wait(output logic [31:0] rsp);
    bit ok = 0;
    rsp = '0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (bus.oRSP_VALID) begin
        ok  = 1;
        rsp = bus.oRSP_DATA;
      end
    end
    check("rsp_timeout", 64'(ok), 64'd1);
    if (ok) begin
      @(negedge clk);
      check("ready_after_rsp", 64'(bus.oCMD_READY), 64'd1);
      check("rsp_one_cycle", 64'(bus.oRSP_VALID), 64'd0);
    end
  endtask

  task automatic do_txn(input logic w, input logic [3:0] a, input logic [31:0] d, input bit noise);
    logic [31:0] exp_rsp, rsp;
    int unsigned rsp0;
    exp_rsp = exp_reg[a];
    if (w) exp_reg[a] = d;
    rsp0 = rsp_n;
    cmd_start(w, a, d);
    if (noise) begin
      repeat (30) @(negedge clk);
      for (int k = 0; k < 40; k++) begin
        bus.iCMD_VALID   = 1'b1;
        bus.iCMD_WRITE   = 1'($urandom);
        bus.iCMD_ADDRESS = 5'($urandom);
        bus.iCMD_DATA    = $urandom;
        @(negedge clk);
      end
      bus.iCMD_VALID = 1'b0;
    end
    cmd_wait(rsp);
    check("rsp_data", 64'(rsp), 64'(exp_rsp));
    check("tgt_reg", 64'(tgt_reg[a]), 64'(exp_reg[a]));
    check("ir_value", 64'(ir_reg), 64'({w, 1'b0, a}));
    if (!w) check("read_tdi_zero", 64'(tdi_or), 64'd0);
    check("rsp_pulses", 64'(rsp_n - rsp0), 64'd1);
  endtask

  task automatic check_tlr(input int unsigned rise0);
    check("tlr_steps", 64'(rise_n - rise0), 64'd6);
    check("tlr_tms_seq", 64'(tms_hist[5:0]), 64'h3E);
    check("tlr_tap_rti", 64'(tap), 64'(RTI));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rise0, rsp0;
    bit ok;
    for (int unsigned i = 0; i < NREG; i++) exp_reg[i] = preload(i);
    rst = 1'b1;
    bus.iCMD_VALID = 1'b0; bus.iCMD_WRITE = 1'b0;
    bus.iCMD_ADDRESS = '0; bus.iCMD_DATA = '0;
    repeat (4) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(bus.oCMD_READY), 64'd0);
    check("rst_rsp_valid", 64'(bus.oRSP_VALID), 64'd0);
    check("rst_rsp_data", 64'(bus.oRSP_DATA), 64'd0);
    rise0 = rise_n;
    rst = 1'b0;
    wait_ready("init_ready");
    check_tlr(rise0);
    check("init_ready_high", 64'(bus.oCMD_READY), 64'd1);

    do_txn(1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 4'd3, 32'h0, 1'b0);
    do_txn(1'b1, 4'd15, 32'h00000001, 1'b0);
    do_txn(1'b0, 4'd0, 32'h0, 1'b0);
    check("reg15_kept", 64'(tgt_reg[15]), 64'd1);

    // Abort a read in the middle of its DR scan.
    rsp0 = rsp_n;
    cmd_start(1'b0, 4'd5, 32'h0);
    ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (tap == SHDR && shift_cnt >= 10) ok = 1;
    end
    check("abort_reach_bit10", 64'(ok), 64'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_tck_low", 64'(tck), 64'd0);
    check("abort_ready_low", 64'(bus.oCMD_READY), 64'd0);
    rise0 = rise_n;
    rst = 1'b0;
    wait_ready("abort_ready");
    check_tlr(rise0);
    check("abort_no_rsp", 64'(rsp_n - rsp0), 64'd0);
    check("abort_reg_kept", 64'(tgt_reg[5]), 64'(exp_reg[5]));
    do_txn(1'b1, 4'd5, 32'h1234_5678, 1'b0);

    // Command requests while busy must be ignored.
    rsp0 = rsp_n;
    do_txn(1'b1, 4'd9, $urandom, 1'b1);
    repeat (250) @(negedge clk);
    check("busy_valid_single_rsp", 64'(rsp_n - rsp0), 64'd1);

    for (int k = 0; k < 8; k++)
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
